// File: rtl/byte_serial_adder_if.sv
// Handshake and operand/result bus for byte_serial_adder.
// master drives start/a/b/ci; slave returns busy/done/s/co.
interface byte_serial_adder_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/byte_serial_adder.sv
// Byte-serial W-bit adder: one add8 pass per clock, LSB byte first.
// Ports: clk, rst_n (sync, active low), bus (slave: start/a/b/ci in, busy/done/s/co out).
module add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, c_i};
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  byte_serial_adder_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [W-1:0]  a_sh_q;
  logic [W-1:0]  b_sh_q;
  logic [W-1:0]  sum_sh_q;
  logic          c_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  s_q;
  logic          co_q;

  logic [7:0]   s8;
  logic         co8;
  logic         last;
  logic [W-1:0] sum_nxt;

  add8 u_add8 (
    .a_i (a_sh_q[7:0]),
    .b_i (b_sh_q[7:0]),
    .c_i (c_q),
    .s_o (s8),
    .c_o (co8)
  );

  assign last = (idx_q == IW'(NBYTES - 1));

  // Top-fed shift: after the final byte the full sum is aligned.
  assign sum_nxt = W'({s8, sum_sh_q} >> 8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered copies of the next state decode.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            c_q      <= bus.ci;
            idx_q    <= '0;
            sum_sh_q <= '0;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 8;
          b_sh_q   <= b_sh_q >> 8;
          sum_sh_q <= sum_nxt;
          c_q      <= co8;
          idx_q    <= idx_q + IW'(1);
          if (last) begin
            s_q  <= sum_nxt;
            co_q <= co8;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder, NBYTES=4.
// Table vectors plus ignored-start, mid-run reset and back-to-back sequences.
module tb_byte_serial_adder;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  byte_serial_adder_if #(.NBYTES(NB)) bus ();

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] es;
    logic         eco;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 1, 0);
  endtask

  // One operation; start optionally kept high (with junk operands) while busy.
  task automatic op(input string nm, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic ci,
                    input logic [W-1:0] es, input logic eco,
                    input bit junk);
    int n;
    bit held;
    logic [W-1:0] s0;
    logic co0;
    wait_idle();
    s0 = bus.s;
    co0 = bus.co;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.ci = ci;
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      bus.a = ~a;
      bus.b = b ^ 32'h5A5A_A5A5;
      bus.ci = ~ci;
    end else begin
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
    end
    chk({nm, "_busy"}, 64'(bus.busy), 1);
    n = 0;
    held = 1;
    while (!bus.done && n < 20) begin
      if (bus.s !== s0 || bus.co !== co0) held = 0;
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 64'(n), NB);
    chk({nm, "_hold"}, 64'(held), 1);
    chk({nm, "_s"}, 64'(bus.s), 64'(es));
    chk({nm, "_co"}, 64'(bus.co), 64'(eco));
    chk({nm, "_busy_dn"}, 64'(bus.busy), 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_pulse"}, 64'(bus.done), 0);
  endtask

  vec_t vt[8];

  initial begin
    int ndone;
    int last_dn;
    int n;
    logic [W:0] q[$];
    logic [W:0] e;
    logic [W:0] sum;

    vt[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vt[1] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
    vt[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
    vt[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vt[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_s", 64'(bus.s), 0);
    chk("rst_co", 64'(bus.co), 0);

    foreach (vt[i])
      op($sformatf("v%0d", i), vt[i].a, vt[i].b, vt[i].ci,
         vt[i].es, vt[i].eco, 0);

    // start held through RUN and DONE with other operands
    op("ign", 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 32'h1010_1011, 1'b0, 1);

    // reset after two byte steps aborts the operation
    wait_idle();
    bus.start = 1'b1;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'h0000_0001;
    bus.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_busy", 64'(bus.busy), 0);
    chk("ar_s", 64'(bus.s), 0);
    chk("ar_co", 64'(bus.co), 0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) n++;
    end
    chk("ar_nodone", 64'(n), 0);
    op("ar_new", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1, 0);

    // continuous start: accepts every NB+2 edges
    wait_idle();
    ndone = 0;
    last_dn = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        chk($sformatf("bb%0d_s", ndone), 64'(bus.s), 64'(e[W-1:0]));
        chk($sformatf("bb%0d_co", ndone), 64'(bus.co), 64'(e[W]));
        if (last_dn >= 0) chk("bb_gap", 64'(c - last_dn), NB + 2);
        last_dn = c;
        ndone++;
      end
      if (c < 20) begin
        bus.start = 1'b1;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.ci = 1'($urandom_range(0, 1));
        if (c % (NB + 2) == 0) begin
          sum = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.ci};
          q.push_back(sum);
        end
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
    end
    chk("bb_count", 64'(ndone), 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/byte_serial_adder.md
Name: byte_serial_adder

Overview:
- Multi-byte adder that reuses a single add8 instance (8-bit adder, carry in/out) once per clock to add two NBYTES-wide operands, least significant byte first.
- Sits directly upstream of add8: owns the operand shift registers and the registered inter-byte carry, presents one byte pair plus carry to add8 per cycle, and collects add8's sum byte and carry-out.
- Trades area for latency against a full-width combinational adder.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..255; total width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A, captured on the accepted start edge.
- b  input  W  operand B, captured on the accepted start edge.
- ci  input  1  carry into byte 0, captured on the accepted start edge.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse: s/co hold a new result.
- s  output  W  sum; holds last result until the next completion.
- co  output  1  carry out of the top byte; held like s.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, s=0, co=0; shift registers, carry register and byte counter cleared. Applies from any state and aborts any operation in progress; no done pulse follows.
- States: IDLE, RUN, DONE. State, busy and done are registered.
- IDLE:
  - start=1 at edge E0: load a_sh<=a, b_sh<=b, c_reg<=ci, idx<=0, sum_sh<=0; go RUN, busy=1.
  - start=0: stay in IDLE.
- RUN, each edge:
  - add8 inputs are a_sh[7:0], b_sh[7:0] and c_reg; add8 is purely combinational.
  - Sum byte shifts into sum_sh from the top: sum_sh <= {s8, sum_sh[W-1:8]}.
  - c_reg <= co8; a_sh and b_sh shift right by 8; idx <= idx+1.
  - On the edge where idx==NBYTES-1: write the completed sum into s, the final co8 into co, and go DONE. That is edge E_NBYTES.
- DONE: done=1 and busy=0 for exactly one cycle; the next edge returns to IDLE with done=0.
- Latency: start accepted at E0 -> done high after E_NBYTES; next start can be accepted at E_(NBYTES+2). A continuously-high start therefore yields one operation every NBYTES+2 cycles.
- start is ignored in RUN and in DONE; a and b may change freely after E0 without affecting the result.
- Arithmetic: {co,s} = a + b + ci modulo 2^(W+1), exact; no saturation; overflow is visible only via co.
- NBYTES=1: RUN lasts one edge; done is high after E1.
- s and co change only on the RUN->DONE edge or on reset.

Test Plan:
- NBYTES=4, a=0x12345678, b=0x11111111, ci=0, start pulsed 1 cycle -> busy for 4 cycles, done pulse after 4th RUN edge, s=0x23456789, co=0.
- a=0x00000001, b=0xFFFFFFFF, ci=0 -> s=0x00000000, co=1. Carry propagates through all four bytes via c_reg.
- a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1; then a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, and the previous s is held until this done.
- start re-asserted during RUN and DONE with different a/b -> ignored; result equals the first operands; s/co unchanged until the correct done.
- rst_n=0 for one edge during RUN (after 2 byte steps) -> IDLE, busy=0, s=0, co=0, no done pulse; a fresh start then completes normally.
- start held high for 20 cycles with random a/b/ci -> one done every 6 cycles; every result matches the a+b+ci model, including co.
